// File: rtl/faims_ramp_ctrl.sv
// rtl/faims_ramp_ctrl.sv - FAIMS pulse/coil driver sequencer with soft ramp and host watchdog
//
// Purpose: latches host FAIMS settings and clamps them so that neither the pulse
// nor the coil work exceeds half the period. Coil work is ramped up and down in
// RAMP_STEP increments every DWELL cycles. The driver is re-synced when period or
// pulse changes while running. If the host stops kicking, coil work is ramped down.
//
// Ports:
//   CLK, i_nReset                    clock, asynchronous active-low reset
//   i_start, i_stop                  level start / stop requests
//   i_cfgValid, o_cfgReady           config write handshake (transfer on valid & ready)
//   i_cfgPeriod, i_cfgPulseLen,
//   i_cfgWork                        config payload: period, pulse length, target work
//   i_kick                           host watchdog kick
//   o_parFaimsPeriod,
//   o_parFaimsPulseLen, o_parWork    driver parameters (work is the ramped value)
//   o_faimsEnable, o_faimsReset      driver enable, driver re-sync (rising edge)
//   o_state                          IDLE=0 ARM=1 RAMP=2 RUN=3 DOWN=4
//   o_cfgErr, o_wdogTrip             sticky status: last write rejected, watchdog fired
module faims_ramp_ctrl #(
  parameter int MIN_PERIOD  = 100,
  parameter int RAMP_STEP   = 4,
  parameter int DWELL       = 1024,
  parameter int WDOG_CYCLES = 2**24
) (
  input  logic       CLK,
  input  logic       i_nReset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_cfgValid,
  output logic       o_cfgReady,
  input  logic [9:0] i_cfgPeriod,
  input  logic [9:0] i_cfgPulseLen,
  input  logic [7:0] i_cfgWork,
  input  logic       i_kick,
  output logic [9:0] o_parFaimsPeriod,
  output logic [9:0] o_parFaimsPulseLen,
  output logic [7:0] o_parWork,
  output logic       o_faimsEnable,
  output logic       o_faimsReset,
  output logic [2:0] o_state,
  output logic       o_cfgErr,
  output logic       o_wdogTrip
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    RAMP = 3'd2,
    RUN  = 3'd3,
    DOWN = 3'd4
  } state_t;

  localparam int DW = $clog2(DWELL + 1);
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DWELL_LD = DW'(DWELL);
  localparam logic [DW-1:0] DW_ONE   = DW'(1);
  localparam logic [WW-1:0] WDOG_LD  = WW'(WDOG_CYCLES);
  localparam logic [WW-1:0] WW_ONE   = WW'(1);
  localparam logic [WW-1:0] WW_ZERO  = '0;
  localparam logic [8:0]    STEP9    = 9'(RAMP_STEP);
  localparam logic [9:0]    MINP     = 10'(MIN_PERIOD);
  localparam bit            WDOG_ON  = (WDOG_CYCLES != 0);

  state_t        state, stateNext;
  logic [9:0]    period, periodNext, pulse, pulseNext;
  logic [7:0]    target, targetNext, work, workNext;
  logic          enable, enableNext, faimsReset, faimsResetNext;
  logic          cfgErr, cfgErrNext, wdogTrip, wdogTripNext;
  logic          cfgReady, cfgReadyNext, armPhase, armPhaseNext;
  logic [DW-1:0] dwellCnt, dwellCntNext;
  logic [WW-1:0] wdogCnt, wdogCntNext;

  logic          xfer, cfgOk, dwellExp, wdogActive, wdogReload, wdogExp;
  logic [9:0]    halfPeriod, pulseClamp;
  logic [7:0]    targetClamp, tgtEff;

  // One ramp step from cur toward goal; 9-bit math so stepping past 255 or below 0 cannot wrap.
  function automatic logic [7:0] stepToward(input logic [7:0] cur, input logic [7:0] goal);
    logic [8:0] c9, g9;
    c9 = {1'b0, cur};
    g9 = {1'b0, goal};
    if (c9 < g9)
      stepToward = ((g9 - c9) <= STEP9) ? goal : cur + STEP9[7:0];
    else
      stepToward = ((c9 - g9) <= STEP9) ? goal : cur - STEP9[7:0];
  endfunction

  assign xfer        = i_cfgValid & cfgReady;
  assign cfgOk       = xfer & (i_cfgPeriod >= MINP);
  assign halfPeriod  = i_cfgPeriod >> 1;
  assign pulseClamp  = (i_cfgPulseLen > halfPeriod) ? halfPeriod : i_cfgPulseLen;
  // When halfPeriod wins the compare it is below i_cfgWork, so it fits in 8 bits.
  assign targetClamp = ({2'b00, i_cfgWork} > halfPeriod) ? halfPeriod[7:0] : i_cfgWork;
  // Decisions use the target being written this cycle so RUN/RAMP react without a bubble.
  assign tgtEff      = cfgOk ? targetClamp : target;
  assign dwellExp    = (dwellCnt == DW_ONE);
  assign wdogActive  = WDOG_ON && ((state == RAMP) || (state == RUN));
  assign wdogReload  = i_kick | cfgOk;
  assign wdogExp     = wdogActive & ~wdogReload & (wdogCnt == WW_ONE);

  always_ff @(posedge CLK or negedge i_nReset) begin
    if (!i_nReset) begin
      state      <= IDLE;
      period     <= 10'd1000;
      pulse      <= 10'd500;
      target     <= 8'd0;
      work       <= 8'd0;
      enable     <= 1'b0;
      faimsReset <= 1'b0;
      cfgErr     <= 1'b0;
      wdogTrip   <= 1'b0;
      cfgReady   <= 1'b1;
      armPhase   <= 1'b0;
      dwellCnt   <= DWELL_LD;
      wdogCnt    <= WDOG_LD;
    end else begin
      state      <= stateNext;
      period     <= periodNext;
      pulse      <= pulseNext;
      target     <= targetNext;
      work       <= workNext;
      enable     <= enableNext;
      faimsReset <= faimsResetNext;
      cfgErr     <= cfgErrNext;
      wdogTrip   <= wdogTripNext;
      cfgReady   <= cfgReadyNext;
      armPhase   <= armPhaseNext;
      dwellCnt   <= dwellCntNext;
      wdogCnt    <= wdogCntNext;
    end
  end

  always_comb begin
    stateNext      = state;
    periodNext     = period;
    pulseNext      = pulse;
    targetNext     = target;
    workNext       = work;
    enableNext     = enable;
    faimsResetNext = 1'b0;
    cfgErrNext     = cfgErr;
    wdogTripNext   = wdogTrip;
    armPhaseNext   = 1'b0;
    dwellCntNext   = dwellCnt;
    wdogCntNext    = wdogCnt;

    // A config transfer is stored whatever the state machine does this cycle.
    if (xfer) begin
      if (cfgOk) begin
        periodNext = i_cfgPeriod;
        pulseNext  = pulseClamp;
        targetNext = targetClamp;
        cfgErrNext = 1'b0;
      end else begin
        cfgErrNext = 1'b1;
      end
    end

    if (wdogReload)
      wdogCntNext = WDOG_LD;
    else if (wdogActive && (wdogCnt != WW_ZERO))
      wdogCntNext = wdogCnt - WW_ONE;
    if (wdogExp)
      wdogTripNext = 1'b1;

    case (state)
      IDLE: begin
        enableNext = 1'b0;
        workNext   = 8'd0;
        if (i_start && !i_stop) begin
          stateNext      = ARM;
          faimsResetNext = 1'b1;
          wdogTripNext   = 1'b0;
        end
      end
      ARM: begin
        if (i_stop) begin
          stateNext    = DOWN;
          dwellCntNext = DWELL_LD;
        end else if (!armPhase) begin
          armPhaseNext = 1'b1;
          enableNext   = 1'b1;
        end else begin
          stateNext    = RAMP;
          dwellCntNext = DWELL_LD;
          wdogCntNext  = WDOG_LD;
        end
      end
      RAMP: begin
        if (i_stop || wdogExp) begin
          stateNext    = DOWN;
          dwellCntNext = DWELL_LD;
        end else begin
          if (dwellExp) begin
            workNext     = stepToward(work, tgtEff);
            dwellCntNext = DWELL_LD;
          end else begin
            dwellCntNext = dwellCnt - DW_ONE;
          end
          if (workNext == tgtEff)
            stateNext = RUN;
        end
      end
      RUN: begin
        if (i_stop || wdogExp) begin
          stateNext    = DOWN;
          dwellCntNext = DWELL_LD;
        end else begin
          if (cfgOk && ((i_cfgPeriod != period) || (pulseClamp != pulse)))
            faimsResetNext = 1'b1;
          if (tgtEff != work) begin
            stateNext    = RAMP;
            dwellCntNext = DWELL_LD;
          end
        end
      end
      DOWN: begin
        if (work == 8'd0) begin
          enableNext = 1'b0;
          stateNext  = IDLE;
        end else if (dwellExp) begin
          workNext     = stepToward(work, 8'd0);
          dwellCntNext = DWELL_LD;
        end else begin
          dwellCntNext = dwellCnt - DW_ONE;
        end
      end
      default: stateNext = IDLE;
    endcase

    cfgReadyNext = !((stateNext == ARM) || (stateNext == DOWN));
  end

  assign o_cfgReady         = cfgReady;
  assign o_parFaimsPeriod   = period;
  assign o_parFaimsPulseLen = pulse;
  assign o_parWork          = work;
  assign o_faimsEnable      = enable;
  assign o_faimsReset       = faimsReset;
  assign o_state            = state;
  assign o_cfgErr           = cfgErr;
  assign o_wdogTrip         = wdogTrip;

endmodule
